// File: rtl/common_pkg.sv
// Shared NoC leaf parameters, credit sizing helpers and the default flit layout.
package common_pkg;

    localparam int DEFAULT_N             = 8;
    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_D_W           = 16;
    localparam int DEFAULT_VC_FIFO_DEPTH = 4;
    localparam int DEFAULT_A_W           = $clog2(DEFAULT_N) + 1;

    // One downstream slot is held back, so usable credits are depth-1.
    function automatic int cred_max(input int depth);
        return depth - 1;
    endfunction

    // Width able to hold 0..cred_max inclusive.
    function automatic int cred_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int vci_w(input int vc_w);
        return (vc_w > 1) ? $clog2(vc_w) : 1;
    endfunction

    typedef struct packed {
        logic [DEFAULT_A_W-1:0] addr;
        logic [DEFAULT_D_W-1:0] data;
    } noc_flit_t;

endpackage

// File: rtl/noc_if.sv
// Leaf link of the binary-tree NoC: one-hot VC strobe plus flit forward, per-VC credit return backward.
interface noc_if #(
    parameter int A_W  = 4,
    parameter int D_W  = 16,
    parameter int VC_W = 2
);
    logic [VC_W-1:0]      vc_target;
    logic [A_W+D_W-1:0]   packet;
    logic [VC_W-1:0]      vc_credit_gnt;

    modport transmitter (output vc_target, output packet, input vc_credit_gnt);
    modport receiver    (input vc_target, input packet, output vc_credit_gnt);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr wins; ptr moves past the winner on advance.
module rr_arbiter #(
    parameter int M  = 4,
    parameter int IW = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [M-1:0]  req,
    input  logic          advance,
    output logic [M-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr;
    logic          found;
    int            idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < M; k++) begin
            idx = (int'(ptr) + k) % M;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (advance)
            ptr <= (gnt_idx == IW'(M - 1)) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: rtl/noc_leaf_injection_arbiter.sv
// Credit-gated round-robin injection of M local requesters into one NoC tree leaf,
// with a registered single-cycle flit output.
module noc_leaf_injection_arbiter
    import common_pkg::*;
#(
    parameter int N             = DEFAULT_N,
    parameter int M             = 4,
    parameter int VC_W          = DEFAULT_VC_W,
    parameter int D_W           = DEFAULT_D_W,
    parameter int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH,
    parameter int A_W           = $clog2(N) + 1,
    parameter int VCI_W         = vci_w(VC_W),
    parameter int CW            = cred_w(VC_FIFO_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [M-1:0]                req_valid,
    output logic [M-1:0]                req_ready,
    input  logic [M-1:0][VCI_W-1:0]     req_vc,
    input  logic [M-1:0][A_W-1:0]       req_addr,
    input  logic [M-1:0][D_W-1:0]       req_data,
    noc_if.transmitter                  to_noc,
    output logic [VC_W-1:0][CW-1:0]     credit_cnt,
    output logic                        idle
);

    localparam int CRED_MAX = cred_max(VC_FIFO_DEPTH);
    localparam int IW       = (M > 1) ? $clog2(M) : 1;

    typedef struct packed {
        logic [A_W-1:0] addr;
        logic [D_W-1:0] data;
    } flit_t;

    logic [VC_W-1:0][CW-1:0] cred_q;
    logic [VC_W-1:0]         inc, dec, at_max;
    logic [M-1:0]            elig, gnt, bad_vc;
    logic [IW-1:0]           gnt_idx;
    logic                    accept;
    logic [VCI_W-1:0]        acc_vc;
    logic [VC_W-1:0]         vc_q;
    flit_t                   flit_q;

    assign inc = to_noc.vc_credit_gnt;

    // Eligibility looks only at registered credits, so a returned credit is usable next cycle.
    always_comb begin
        elig   = '0;
        bad_vc = '0;
        for (int i = 0; i < M; i++) begin
            bad_vc[i] = req_valid[i] && (int'(req_vc[i]) >= VC_W);
            if (req_valid[i] && enable && !rst && !bad_vc[i])
                elig[i] = (cred_q[req_vc[i]] != '0);
        end
    end

    rr_arbiter #(.M(M), .IW(IW)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .advance (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // A grant is only issued to a valid requester, so every grant is an accept.
    assign req_ready = gnt;
    assign accept    = |gnt;
    assign acc_vc    = req_vc[gnt_idx];

    always_comb begin
        dec    = '0;
        at_max = '0;
        for (int v = 0; v < VC_W; v++) begin
            dec[v]    = accept && (int'(acc_vc) == v);
            at_max[v] = (cred_q[v] == CW'(CRED_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_W; v++)
                cred_q[v] <= CW'(CRED_MAX);
        end else begin
            for (int v = 0; v < VC_W; v++) begin
                if (inc[v] && !dec[v] && !at_max[v])
                    cred_q[v] <= cred_q[v] + 1'b1;
                else if (dec[v] && !inc[v])
                    cred_q[v] <= cred_q[v] - 1'b1;
            end
        end
    end

    // packet only loads on accept so it never toggles while vc_target is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            vc_q   <= '0;
            flit_q <= '0;
        end else if (accept) begin
            vc_q   <= VC_W'(1) << acc_vc;
            flit_q <= '{addr: req_addr[gnt_idx], data: req_data[gnt_idx]};
        end else begin
            vc_q   <= '0;
        end
    end

    assign to_noc.vc_target = vc_q;
    assign to_noc.packet    = flit_q;
    assign credit_cnt       = cred_q;
    assign idle             = (&at_max) && (vc_q == '0);

    a_credit_overflow: assert property (@(posedge clk) disable iff (rst) !(|(inc & ~dec & at_max)));
    a_illegal_vc:      assert property (@(posedge clk) disable iff (rst) !(|bad_vc));

endmodule

// File: tb/tb_noc_leaf_injection_arbiter.sv
// Randomized and directed bench for noc_leaf_injection_arbiter against a cycle-level behavioural model.
module tb_noc_leaf_injection_arbiter;

    localparam int N        = 8;
    localparam int M        = 4;
    localparam int VC_W     = 2;
    localparam int D_W      = 16;
    localparam int DEPTH    = 4;
    localparam int A_W      = $clog2(N) + 1;
    localparam int VCI_W    = 1;
    localparam int CW       = 2;
    localparam int CRED_MAX = DEPTH - 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     enable;
    logic [M-1:0]             req_valid;
    logic [M-1:0]             req_ready;
    logic [M-1:0][VCI_W-1:0]  req_vc;
    logic [M-1:0][A_W-1:0]    req_addr;
    logic [M-1:0][D_W-1:0]    req_data;
    logic [VC_W-1:0][CW-1:0]  credit_cnt;
    logic                     idle;

    noc_if #(.A_W(A_W), .D_W(D_W), .VC_W(VC_W)) nif ();

    noc_leaf_injection_arbiter #(
        .N(N), .M(M), .VC_W(VC_W), .D_W(D_W), .VC_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_vc     (req_vc),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .to_noc     (nif),
        .credit_cnt (credit_cnt),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: credits per VC, priority pointer, and what the leaf link shows.
    int                    mcred[VC_W];
    int                    mptr;
    logic [VC_W-1:0]       mvt;
    logic [A_W+D_W-1:0]    mpkt;
    int                    last_grant;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called with inputs already driven (posedge+1); checks the grant, then the post-edge state.
    task automatic cycle();
        int g;
        bit all_full;
        logic [M-1:0] exp_rdy;
        #1;
        g = -1;
        if (!rst && enable) begin
            for (int k = 0; k < M; k++) begin
                int i;
                i = (mptr + k) % M;
                if (g < 0 && req_valid[i] && mcred[req_vc[i]] > 0) g = i;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        last_grant = g;

        if (rst) begin
            for (int v = 0; v < VC_W; v++) mcred[v] = CRED_MAX;
            mptr = 0;
            mvt  = '0;
            mpkt = '0;
        end else begin
            for (int v = 0; v < VC_W; v++) begin
                if (nif.vc_credit_gnt[v]) mcred[v] = mcred[v] + 1;
                if (g >= 0 && int'(req_vc[g]) == v) mcred[v] = mcred[v] - 1;
            end
            if (g >= 0) begin
                mptr = (g + 1) % M;
                mvt  = '0;
                mvt[req_vc[g]] = 1'b1;
                mpkt = {req_addr[g], req_data[g]};
            end else begin
                mvt = '0;
            end
        end

        @(posedge clk);
        #1;
        chk("vc_target", 64'(nif.vc_target), 64'(mvt));
        chk("packet", 64'(nif.packet), 64'(mpkt));
        all_full = 1'b1;
        for (int v = 0; v < VC_W; v++) begin
            chk($sformatf("credit_cnt[%0d]", v), 64'(credit_cnt[v]), 64'(mcred[v]));
            if (mcred[v] != CRED_MAX) all_full = 1'b0;
        end
        chk("idle", 64'(idle), 64'(all_full && (mvt == '0)));
    endtask

    task automatic rand_payload();
        for (int i = 0; i < M; i++) begin
            req_addr[i] = A_W'($urandom());
            req_data[i] = D_W'($urandom());
        end
    endtask

    task automatic no_returns();
        nif.vc_credit_gnt = '0;
    endtask

    task automatic return_all_outstanding();
        for (int v = 0; v < VC_W; v++) nif.vc_credit_gnt[v] = (mcred[v] < CRED_MAX);
    endtask

    task automatic rand_drive(input int pv, input int pen, input int pret, input int prst);
        rst    = ($urandom_range(99) < prst);
        enable = ($urandom_range(99) < pen);
        for (int i = 0; i < M; i++) begin
            req_valid[i] = ($urandom_range(99) < pv);
            req_vc[i]    = VCI_W'($urandom_range(VC_W - 1));
        end
        rand_payload();
        for (int v = 0; v < VC_W; v++)
            nif.vc_credit_gnt[v] = (mcred[v] < CRED_MAX) && ($urandom_range(99) < pret);
    endtask

    task automatic drain();
        rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < CRED_MAX + 2; c++) begin
            return_all_outstanding();
            cycle();
        end
        no_returns();
    endtask

    initial begin
        for (int v = 0; v < VC_W; v++) mcred[v] = CRED_MAX;
        mptr = 0; mvt = '0; mpkt = '0; last_grant = -1;

        // Reset held with every requester asking.
        rst = 1'b1; enable = 1'b1; req_valid = '1; req_vc = '0;
        rand_payload(); no_returns();
        for (int c = 0; c < 3; c++) cycle();
        chk("reset_idle", 64'(idle), 64'd1);
        chk("reset_cred0", 64'(credit_cnt[0]), 64'(CRED_MAX));

        // Fairness on VC0 with each flit's credit looped straight back.
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            req_valid = '1; req_vc = '0; rand_payload();
            nif.vc_credit_gnt = '0;
            nif.vc_credit_gnt[0] = mvt[0] && (mcred[0] < CRED_MAX);
            cycle();
            chk("rr_order", 64'(last_grant), 64'(c % M));
        end
        drain();

        // Credit exhaustion on VC1 for a lone requester, then a single return pulse.
        req_valid = 4'b0001; req_vc = '0; req_vc[0] = 1'b1; no_returns();
        for (int c = 0; c < 5; c++) begin rand_payload(); cycle(); end
        chk("exhausted", 64'(credit_cnt[1]), 64'd0);
        nif.vc_credit_gnt = 2'b10; rand_payload(); cycle();
        chk("no_same_cycle_use", 64'(last_grant), -64'sd1);
        no_returns(); rand_payload(); cycle();
        chk("use_next_cycle", 64'(last_grant), 64'd0);
        drain();

        // Accept and return on VC0 together, then VC0 empty while VC1 is full.
        req_valid = 4'b0001; req_vc = '0; rand_payload(); cycle();
        nif.vc_credit_gnt = 2'b01; rand_payload(); cycle();
        chk("simul_unchanged", 64'(credit_cnt[0]), 64'(CRED_MAX - 1));
        no_returns();
        for (int c = 0; c < 2; c++) begin rand_payload(); cycle(); end
        req_valid = 4'b0011; req_vc[1] = 1'b1; rand_payload(); cycle();
        chk("skip_empty_vc", 64'(last_grant), 64'd1);
        drain();

        // Enable dropped mid-burst; idle follows the final credit return.
        enable = 1'b1;
        for (int c = 0; c < 2; c++) begin rand_drive(100, 100, 0, 0); cycle(); end
        enable = 1'b0;
        for (int c = 0; c < 6; c++) begin
            req_valid = '1; rand_payload();
            for (int v = 0; v < VC_W; v++) nif.vc_credit_gnt[v] = (mcred[v] < CRED_MAX) && c[0];
            cycle();
        end
        chk("enable_idle", 64'(idle), 64'd1);
        enable = 1'b1;
        drain();

        // Reset in the middle of a VC0 burst with one credit left.
        req_valid = '1; req_vc = '0;
        for (int c = 0; c < 2; c++) begin rand_payload(); cycle(); end
        rst = 1'b1; rand_payload(); cycle();
        rst = 1'b0; rand_payload(); cycle();
        chk("post_reset_first", 64'(last_grant), 64'd0);
        drain();

        // Randomized traffic across several load profiles.
        for (int c = 0; c < 3000; c++) begin
            case (c / 750)
                0: rand_drive(60, 95, 40, 1);
                1: rand_drive(100, 100, 20, 0);
                2: rand_drive(90, 70, 80, 2);
                default: rand_drive(30, 100, 60, 1);
            endcase
            cycle();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/noc_leaf_injection_arbiter.md
# noc_leaf_injection_arbiter

Shares one leaf transmit port of the binary-tree NoC among M local requesters. Each requester presents an address/data flit on a chosen virtual channel; the block tracks per-VC downstream credits, round-robin arbitrates among requesters whose VC has credit, and drives one registered flit per cycle into the tree's `leaf_rx` interface. It sits between a cluster of PEs/DMA engines and a single tree leaf.

## Interface
Parameters:
- `N`, `DEFAULT_N`: tree leaf count; `A_W = $clog2(N)+1` is derived.
- `M`, 4: number of requesters, ≥1.
- `VC_W`, `DEFAULT_VC_W`: number of VCs; `vc_target` and `vc_credit_gnt` are one bit per VC.
- `D_W`, `DEFAULT_D_W`: flit data width.
- `VC_FIFO_DEPTH`, `DEFAULT_VC_FIFO_DEPTH`: downstream FIFO parameter. Usable credits per VC are `CRED_MAX = VC_FIFO_DEPTH-1`.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: when low, no new grants are issued. In-flight output still completes.
- `req_valid`, in, [M-1:0]: request present.
- `req_ready`, out, [M-1:0]: grant. A flit is accepted when `req_valid[i] & req_ready[i]`.
- `req_vc`, in, [M-1:0][VCI_W-1:0]: VC index, with `VCI_W = max(1,$clog2(VC_W))`.
- `req_addr`, in, [M-1:0][A_W-1:0]: destination leaf address.
- `req_data`, in, [M-1:0][D_W-1:0]: payload.
- `to_noc`, `noc_if.transmitter`: `vc_target`, `packet` (addr, data) out; `vc_credit_gnt` in.
- `credit_cnt`, out, [VC_W-1:0][CW-1:0]: current credits, with `CW = $clog2(CRED_MAX+1)`.
- `idle`, out, 1: all credits at `CRED_MAX` and no flit on `to_noc`.

## Operation
- **Credit counters.** There is one counter per VC.
  - Reset value is `CRED_MAX`.
  - Decrement by 1 when a flit on that VC is accepted.
  - Increment by 1 when `vc_credit_gnt[v]` is high.
  - If both happen in the same cycle, the counter is unchanged.
  - An increment while the counter is at `CRED_MAX` is a protocol error. The counter holds at `CRED_MAX` and a simulation assertion fires.
- **Eligibility.** Requester i is eligible when `req_valid[i] & enable & credit_cnt[req_vc[i]] != 0`, evaluated from the registered counter.
  - A credit returned in cycle t can be used no earlier than t+1.
  - `req_vc >= VC_W` is illegal. It is never granted and a simulation assertion fires.
- **Arbitration.** Round-robin with a priority pointer `ptr` (reset 0).
  - At most one grant per cycle: `req_ready` is one-hot or zero.
  - The grant goes to the first eligible requester at or after `ptr`, wrapping modulo M.
  - After a grant to i, `ptr` becomes `(i+1) mod M`. With no grant, `ptr` holds.
  - `req_ready` is combinational from `req_valid`, `req_vc`, `enable`, registered counters and `ptr`. It has no path from `vc_credit_gnt`.
- **Output register.** On accept from requester i:
  - Next cycle, `vc_target = 1 << req_vc[i]` and `packet = {req_addr[i], req_data[i]}`.
  - If nothing is accepted, `vc_target = 0` next cycle. `packet` holds its last value; it is don't-care, but it must not glitch in the RTL.
- **Enable.** Deasserting `enable` stops grants in that same cycle. Counters keep tracking returns, so `idle` asserts once the downstream FIFOs drain.
- **Reset mid-operation.**
  - All counters return to `CRED_MAX`, `ptr` to 0, and `vc_target` to 0.
  - Any flit registered but not yet presented is dropped.
  - The downstream FIFOs are reset by the same `rst`.
- **Reset values.** `req_ready=0`, `vc_target=0`, `packet=0`, `credit_cnt=CRED_MAX` on every VC, `idle=1`.

## Timing
- Latency is 1 cycle: accept at edge t, flit visible on `to_noc` during cycle t+1 for exactly one cycle.
- Throughput is 1 flit/cycle sustained, back-to-back flits allowed on the same or different VCs.
- A single VC can sustain full rate only if the credit round trip is ≤ `CRED_MAX` cycles. Otherwise it stalls at 0 credits.
- The combinational path is `req_valid` → `req_ready`: one RR priority encode over M. The `to_noc` outputs come directly from flops.

## Structure
- `common_pkg` holds:
  - the `CRED_MAX`/`CW` computation as functions of `VC_FIFO_DEPTH`;
  - `VCI_W`;
  - a `noc_flit_t` struct {addr, data}, parameterized by width via localparams in the consumer.
- Sub-module `rr_arbiter #(M)`:
  - inputs `req[M-1:0]` and `advance`;
  - outputs `gnt[M-1:0]` (one-hot) and `gnt_idx`;
  - owns `ptr`.
- The top holds the credit counters, eligibility masking and the output register. Target size is about 200 lines total.

## Test plan
- **Reset.** Hold `rst` 3 cycles with all `req_valid=1` → `req_ready=0`, `vc_target=0`, `idle=1`, every `credit_cnt=CRED_MAX` (e.g. 3 for depth 4).
- **Fairness.** M=4, all valid on VC0, `vc_credit_gnt` looped back each cycle after a flit → grants 0,1,2,3,0… one per cycle; `to_noc` shows matching addr/data one cycle after each grant.
- **Credit exhaustion.** VC_FIFO_DEPTH=4, single requester on VC1, no credit returns → exactly 3 flits accepted, then `req_ready=0`. One `vc_credit_gnt[1]` pulse at cycle t → next grant at t+1, not t.
- **Simultaneous events.** Accept on VC0 in the same cycle as `vc_credit_gnt[0]` → `credit_cnt[0]` unchanged. With VC0 empty and VC1 full, requester 0 on VC0 is skipped and requester 1 on VC1 is granted.
- **Enable/idle.** Deassert `enable` mid-burst → no grant from that cycle on. Return all outstanding credits → `idle` rises the cycle after the last return.
- **Reset mid-traffic.** Assert `rst` during a burst with VC0 at 1 credit → next cycle `vc_target=0`, `credit_cnt[0]=CRED_MAX`, and the first post-reset grant goes to requester 0.
